// File: rtl/ocp_sram_slave_pkg.sv
// ----------------------------------------------------------------------------
// ocp_sram_slave_pkg : bus widths and OCP command/response codes
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ocp_sram_slave_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BEN_WIDTH  = DATA_WIDTH / 8;

  localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
  localparam logic [2:0] OCP_CMD_WRITE = 3'b001;
  localparam logic [2:0] OCP_CMD_READ  = 3'b010;

  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
  localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/ocp_sram_array.sv
// ----------------------------------------------------------------------------
// ocp_sram_array : single-port sync RAM, byte write enables, held read register
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ocp_sram_array #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = 32
) (
  input  logic                   clk,
  input  logic                   i_en,
  input  logic [WIDTH/8-1:0]     i_we,
  input  logic [DEPTH_LOG2-1:0]  i_addr,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata
);

  logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [WIDTH-1:0] r_rdata;

  // Read-first: the output register captures the pre-write word when enabled.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int k = 0; k < WIDTH/8; k++) begin
        if (i_we[k]) begin
          r_mem[i_addr][k*8 +: 8] <= i_wdata[k*8 +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ocp_sram_slave.sv
// ----------------------------------------------------------------------------
// ocp_sram_slave : OCP slave responder in front of a byte-enabled SRAM
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ocp_sram_slave
  import ocp_sram_slave_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int WAIT_STATES    = 0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_MAddr,
  input  logic [2:0]            i_MCmd,
  input  logic [DATA_WIDTH-1:0] i_MData,
  input  logic [BEN_WIDTH-1:0]  i_MByteEn,
  output logic                  o_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_SData,
  output logic [1:0]            o_SResp
);

  localparam logic [2:0] ST_IDLE   = 3'b001;
  localparam logic [2:0] ST_WAIT   = 3'b010;
  localparam logic [2:0] ST_RESP   = 3'b100;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("ocp_sram_slave: WAIT_STATES must be in 0..15");
  end

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [3:0]            r_cnt;
  logic                  r_rd;
  logic                  r_err;
  logic                  w_start;
  logic                  w_is_rd;
  logic                  w_is_wr;
  logic                  w_err;
  logic                  w_mem_en;
  logic [BEN_WIDTH-1:0]  w_mem_we;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused_addr;

  assign w_is_rd  = (i_MCmd == OCP_CMD_READ);
  assign w_is_wr  = (i_MCmd == OCP_CMD_WRITE);
  assign w_start  = (r_state == ST_IDLE) && (i_MCmd != OCP_CMD_IDLE);
  assign w_err    = !(w_is_rd || w_is_wr) ||
                    (|i_MAddr[ADDR_WIDTH-1:MEM_WORDS_LOG2+2]);
  assign w_mem_en = w_start && !w_err;
  assign w_mem_we = w_is_wr ? i_MByteEn : '0;

  // Byte offset within a word carries no meaning for a word-wide SRAM.
  assign w_unused_addr = ^i_MAddr[1:0];

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (i_MCmd == OCP_CMD_IDLE) w_state_nxt = ST_IDLE;
        else if (WAIT_STATES == 0)  w_state_nxt = ST_RESP;
        else                        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: w_state_nxt = (r_cnt == 4'd1) ? ST_RESP : ST_WAIT;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_rd  <= w_is_rd;
        r_err <= w_err;
        r_cnt <= WAIT_INIT;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  ocp_sram_array #(
    .DEPTH_LOG2 (MEM_WORDS_LOG2),
    .WIDTH      (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_addr  (i_MAddr[MEM_WORDS_LOG2+1:2]),
    .i_wdata (i_MData),
    .o_rdata (w_rdata)
  );

  assign o_SCmdAccept = (r_state == ST_IDLE) || (i_MCmd == OCP_CMD_IDLE);
  assign o_SResp      = (r_state != ST_RESP) ? OCP_RESP_NULL :
                        (r_err ? OCP_RESP_ERR : OCP_RESP_DVA);
  assign o_SData      = ((r_state == ST_RESP) && r_rd && !r_err) ? w_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_ocp_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_ocp_sram_slave : directed bench, one instance with 0 and one with 3 wait states
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ocp_sram_slave;
  import ocp_sram_slave_pkg::*;

  logic             clk;
  logic             nrst;
  logic [1:0][2:0]  cmd;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0][3:0]  ben;
  logic [1:0]       acc;
  logic [1:0][1:0]  resp;
  logic [1:0][31:0] sdata;

  int checks = 0;
  int errors = 0;

  ocp_sram_slave #(.MEM_WORDS_LOG2(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .nrst(nrst), .i_MAddr(addr[0]), .i_MCmd(cmd[0]),
    .i_MData(wdata[0]), .i_MByteEn(ben[0]), .o_SCmdAccept(acc[0]),
    .o_SData(sdata[0]), .o_SResp(resp[0])
  );

  ocp_sram_slave #(.MEM_WORDS_LOG2(10), .WAIT_STATES(3)) dut3 (
    .clk(clk), .nrst(nrst), .i_MAddr(addr[1]), .i_MCmd(cmd[1]),
    .i_MData(wdata[1]), .i_MByteEn(ben[1]), .o_SCmdAccept(acc[1]),
    .o_SData(sdata[1]), .o_SResp(resp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Issue one command, drop MCmd after acceptance, wait for its response.
  // Called 1 time unit after a rising edge; returns likewise.
  task automatic txn(input int d, input logic [2:0] c, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [1:0] r, output logic [31:0] rd, output int lat);
    int n;
    cmd[d] = c; addr[d] = a; wdata[d] = wd; ben[d] = be;
    r = OCP_RESP_NULL; rd = '0; lat = -1; n = 0;
    @(negedge clk);
    while (!acc[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 cmd[d] = OCP_CMD_IDLE;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (resp[d] !== OCP_RESP_NULL) begin
        r = resp[d]; rd = sdata[d]; lat = i;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    cmd[0] = OCP_CMD_READ; addr[0] = 32'h10;
    #12;
    checks++; if (acc[0] !== 1'b1) begin errors++; $display("FAIL rst_accept: got %b expected 1", acc[0]); end
    checks++; if (resp[0] !== OCP_RESP_NULL) begin errors++; $display("FAIL rst_resp: got %b expected 00", resp[0]); end
    checks++; if (sdata[0] !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", sdata[0]); end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1 cmd[0] = OCP_CMD_IDLE;
    @(negedge clk);
    checks++; if (resp[0] !== OCP_RESP_DVA) begin errors++; $display("FAIL rst_first_read: got %b expected 01", resp[0]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read;
    logic [1:0] r; logic [31:0] rd; int lat;
    txn(0, OCP_CMD_WRITE, 32'h10, 32'hDEADBEEF, 4'b1111, r, rd, lat);
    checks++; if (r !== OCP_RESP_DVA || lat != 1) begin errors++; $display("FAIL wr_resp: got resp %b lat %0d expected 01 lat 1", r, lat); end
    txn(0, OCP_CMD_READ, 32'h10, 32'h0, 4'b1111, r, rd, lat);
    checks++; if (r !== OCP_RESP_DVA || lat != 1) begin errors++; $display("FAIL rd_resp: got resp %b lat %0d expected 01 lat 1", r, lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    @(negedge clk);
    checks++; if (resp[0] !== OCP_RESP_NULL || sdata[0] !== 32'h0) begin errors++; $display("FAIL rd_after: got resp %b data %h expected 00 0", resp[0], sdata[0]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_byte_en;
    logic [1:0] r; logic [31:0] rd; int lat;
    txn(0, OCP_CMD_WRITE, 32'h10, 32'h00001100, 4'b0010, r, rd, lat);
    checks++; if (r !== OCP_RESP_DVA) begin errors++; $display("FAIL ben_wr: got %b expected 01", r); end
    txn(0, OCP_CMD_READ, 32'h10, 32'h0, 4'b1111, r, rd, lat);
    checks++; if (rd !== 32'hDEAD11EF) begin errors++; $display("FAIL ben_merge: got %h expected dead11ef", rd); end
    txn(0, OCP_CMD_WRITE, 32'h10, 32'hFFFFFFFF, 4'b0000, r, rd, lat);
    checks++; if (r !== OCP_RESP_DVA) begin errors++; $display("FAIL ben_zero_resp: got %b expected 01", r); end
    txn(0, OCP_CMD_READ, 32'h13, 32'h0, 4'b1111, r, rd, lat);
    checks++; if (rd !== 32'hDEAD11EF) begin errors++; $display("FAIL ben_zero_noop: got %h expected dead11ef", rd); end
  endtask

  task automatic test_wait_states;
    logic [1:0] r; logic [31:0] rd; int lat;
    txn(1, OCP_CMD_WRITE, 32'h20, 32'h12345678, 4'b1111, r, rd, lat);
    checks++; if (r !== OCP_RESP_DVA || lat != 4) begin errors++; $display("FAIL ws_wr: got resp %b lat %0d expected 01 lat 4", r, lat); end
    cmd[1] = OCP_CMD_READ; addr[1] = 32'h20;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if (resp[1] !== OCP_RESP_NULL || acc[1] !== 1'b0) begin errors++; $display("FAIL ws_wait%0d: got resp %b accept %b expected 00 0", i, resp[1], acc[1]); end
    end
    @(negedge clk);
    checks++; if (resp[1] !== OCP_RESP_DVA || sdata[1] !== 32'h12345678) begin errors++; $display("FAIL ws_resp: got resp %b data %h expected 01 12345678", resp[1], sdata[1]); end
    @(posedge clk);
    #1 cmd[1] = OCP_CMD_IDLE;
    @(negedge clk);
    checks++; if (resp[1] !== OCP_RESP_NULL || acc[1] !== 1'b1) begin errors++; $display("FAIL ws_after: got resp %b accept %b expected 00 1", resp[1], acc[1]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_errors;
    logic [1:0] r; logic [31:0] rd; int lat;
    txn(0, OCP_CMD_WRITE, 32'h0, 32'hA5A5A5A5, 4'b1111, r, rd, lat);
    txn(0, OCP_CMD_WRITE, 32'h1000, 32'h0, 4'b1111, r, rd, lat);
    checks++; if (r !== OCP_RESP_ERR || lat != 1) begin errors++; $display("FAIL err_oob_wr: got resp %b lat %0d expected 11 lat 1", r, lat); end
    txn(0, OCP_CMD_READ, 32'h0, 32'h0, 4'b1111, r, rd, lat);
    checks++; if (r !== OCP_RESP_DVA || rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL err_no_modify: got resp %b data %h expected 01 a5a5a5a5", r, rd); end
    txn(0, 3'b011, 32'h0, 32'h0, 4'b1111, r, rd, lat);
    checks++; if (r !== OCP_RESP_ERR || rd !== 32'h0) begin errors++; $display("FAIL err_badcmd: got resp %b data %h expected 11 0", r, rd); end
    txn(0, OCP_CMD_READ, 32'h1000, 32'h0, 4'b1111, r, rd, lat);
    checks++; if (r !== OCP_RESP_ERR || rd !== 32'h0) begin errors++; $display("FAIL err_oob_rd: got resp %b data %h expected 11 0", r, rd); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] r; logic [31:0] rd; int lat;
    logic [31:0] a, dv;
    for (int i = 0; i < 8; i++) begin
      a  = 32'h80 + 32'(4 * (i / 2));
      dv = 32'hC0DE0000 + 32'(i / 2) * 32'h00010101;
      if (i % 2 == 0) begin
        txn(0, OCP_CMD_WRITE, a, dv, 4'b1111, r, rd, lat);
        checks++; if (r !== OCP_RESP_DVA || lat != 1) begin errors++; $display("FAIL b2b_wr%0d: got resp %b lat %0d expected 01 lat 1", i, r, lat); end
      end else begin
        txn(0, OCP_CMD_READ, a, 32'h0, 4'b1111, r, rd, lat);
        checks++; if (r !== OCP_RESP_DVA || lat != 1 || rd !== dv) begin errors++; $display("FAIL b2b_rd%0d: got resp %b lat %0d data %h expected 01 lat 1 data %h", i, r, lat, rd, dv); end
      end
    end
    // Held command across the response cycle waits one IDLE cycle.
    cmd[0] = OCP_CMD_READ; addr[0] = 32'h84;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (resp[0] !== OCP_RESP_DVA || acc[0] !== 1'b0 || sdata[0] !== 32'hC0DF0101) begin errors++; $display("FAIL hold_resp: got resp %b accept %b data %h expected 01 0 c0df0101", resp[0], acc[0], sdata[0]); end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (resp[0] !== OCP_RESP_NULL || acc[0] !== 1'b1) begin errors++; $display("FAIL hold_idle: got resp %b accept %b expected 00 1", resp[0], acc[0]); end
    @(posedge clk);
    #1 cmd[0] = OCP_CMD_IDLE;
    @(negedge clk);
    checks++; if (resp[0] !== OCP_RESP_DVA) begin errors++; $display("FAIL hold_second: got resp %b expected 01", resp[0]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    logic [1:0] r; logic [31:0] rd; int lat; int spurious;
    cmd[1] = OCP_CMD_READ; addr[1] = 32'h20;
    @(posedge clk);
    #1 cmd[1] = OCP_CMD_IDLE;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++; if (resp[1] !== OCP_RESP_NULL || acc[1] !== 1'b1) begin errors++; $display("FAIL mid_rst: got resp %b accept %b expected 00 1", resp[1], acc[1]); end
    @(negedge clk);
    nrst = 1'b1;
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp[1] !== OCP_RESP_NULL) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL mid_no_resp: got %0d responses expected 0", spurious); end
    @(posedge clk);
    #1;
    txn(1, OCP_CMD_READ, 32'h20, 32'h0, 4'b1111, r, rd, lat);
    checks++; if (r !== OCP_RESP_DVA || lat != 4 || rd !== 32'h12345678) begin errors++; $display("FAIL mid_recover: got resp %b lat %0d data %h expected 01 lat 4 data 12345678", r, lat, rd); end
  endtask

  initial begin
    cmd = '0; addr = '0; wdata = '0; ben = '0;
    test_reset();
    test_write_read();
    test_byte_en();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
